// File: rtl/nibble_serial_subtractor_if.sv
// nibble_serial_subtractor_if
// Groups the request/result signals of nibble_serial_subtractor.
//   master : drives start, a, b, bin; observes busy, done, diff, bout, zero, ovf
//   slave  : the subtractor side (directions reversed)
// With NIBSUB_CMP_EN defined, the compare flags lt_u and lt_s are added.
interface nibble_serial_subtractor_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             zero;
   logic             ovf;
`ifdef NIBSUB_CMP_EN
   logic             lt_u;
   logic             lt_s;
`endif

`ifdef NIBSUB_CMP_EN
   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout, zero, ovf, lt_u, lt_s
   );
   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout, zero, ovf, lt_u, lt_s
   );
`else
   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout, zero, ovf
   );
   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout, zero, ovf
   );
`endif
endinterface

// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor
// Computes A - B - BIN one 4-bit slice per clock (LSB slice first), using the
// adder form A + ~B + ~borrow per slice. N = WIDTH/4 busy cycles, then a
// one-cycle DONE state in which a new start may be accepted back-to-back.
// WIDTH must be a multiple of 4 and at least 8.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      slave side of nibble_serial_subtractor_if (start/a/b/bin in,
//            busy/done/diff/bout/zero/ovf out, all outputs registered)
// Optional: NIBSUB_CMP_EN adds registered compare flags lt_u and lt_s.
module nibble_serial_subtractor #(
   parameter int unsigned WIDTH = 32
) (
   input logic                         clk,
   input logic                         reset_n,
   nibble_serial_subtractor_if.slave   bus
);

   localparam int unsigned N    = WIDTH / 4;
   localparam int unsigned CntW = $clog2(N);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t           state;
   logic [CntW-1:0]  cnt;
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic             borrowQ;
   logic             busyQ;
   logic             doneQ;
   logic [WIDTH-1:0] diffQ;
   logic             boutQ;
   logic             zeroQ;
   logic             ovfQ;
`ifdef NIBSUB_CMP_EN
   logic             ltUQ;
   logic             ltSQ;
`endif

   logic [3:0]       aNib;
   logic [3:0]       bNib;
   logic [4:0]       sum;
   logic [WIDTH-1:0] diffNext;
   logic             ovfNext;

   // Select the active slice and splice its result into the running difference.
   always_comb begin
      aNib     = '0;
      bNib     = '0;
      diffNext = diffQ;
      for (int k = 0; k < int'(N); k++) begin
         if (cnt == CntW'(k)) begin
            aNib = opA[4*k +: 4];
            bNib = opB[4*k +: 4];
         end
      end
      // Carry-in is the inverse of the running borrow.
      sum = {1'b0, aNib} + {1'b0, ~bNib} + {4'b0000, ~borrowQ};
      for (int k = 0; k < int'(N); k++) begin
         if (cnt == CntW'(k)) begin
            diffNext[4*k +: 4] = sum[3:0];
         end
      end
      ovfNext = (opA[WIDTH-1] != opB[WIDTH-1]) && (diffNext[WIDTH-1] != opA[WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= StIdle;
         cnt     <= '0;
         opA     <= '0;
         opB     <= '0;
         borrowQ <= 1'b0;
         busyQ   <= 1'b0;
         doneQ   <= 1'b0;
         diffQ   <= '0;
         boutQ   <= 1'b0;
         zeroQ   <= 1'b0;
         ovfQ    <= 1'b0;
`ifdef NIBSUB_CMP_EN
         ltUQ    <= 1'b0;
         ltSQ    <= 1'b0;
`endif
      end else begin
         doneQ <= 1'b0;
         unique case (state)
            StIdle, StDone: begin
               if (bus.start) begin
                  opA     <= bus.a;
                  opB     <= bus.b;
                  borrowQ <= bus.bin;
                  cnt     <= '0;
                  busyQ   <= 1'b1;
                  state   <= StRun;
               end else begin
                  state   <= StIdle;
               end
            end
            StRun: begin
               diffQ   <= diffNext;
               borrowQ <= ~sum[4];
               cnt     <= cnt + CntW'(1);
               if (cnt == CntW'(N - 1)) begin
                  busyQ <= 1'b0;
                  doneQ <= 1'b1;
                  boutQ <= ~sum[4];
                  zeroQ <= (diffNext == '0);
                  ovfQ  <= ovfNext;
`ifdef NIBSUB_CMP_EN
                  ltUQ  <= ~sum[4];
                  ltSQ  <= diffNext[WIDTH-1] ^ ovfNext;
`endif
                  state <= StDone;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign bus.busy = busyQ;
   assign bus.done = doneQ;
   assign bus.diff = diffQ;
   assign bus.bout = boutQ;
   assign bus.zero = zeroQ;
   assign bus.ovf  = ovfQ;
`ifdef NIBSUB_CMP_EN
   assign bus.lt_u = ltUQ;
   assign bus.lt_s = ltSQ;
`endif

endmodule

// File: doc/nibble_serial_subtractor.md
# nibble_serial_subtractor

Multi-cycle WIDTH-bit subtractor that computes A − B − BIN one 4-bit slice per clock. Each slice reuses the 4-bit fast-adder equation: A plus the complement of B plus carry, with carry-in = NOT borrow. The block handles the subtract and borrow direction for the ALU-side datapath, where a full-width carry-lookahead subtractor is not justified. Results are held after completion until the next accepted start.

## Interface

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 4 and at least 8; N = WIDTH/4 slices.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on clk rising edge.
- start  in  1  request; accepted only in IDLE or DONE.
- a  in  WIDTH  minuend, captured at accept.
- b  in  WIDTH  subtrahend, captured at accept.
- bin  in  1  borrow-in, active high, captured at accept.
- busy  out  1  high while slices are being computed.
- done  out  1  one-cycle pulse when the result becomes valid.
- diff  out  WIDTH  difference, A − B − BIN mod 2^WIDTH.
- bout  out  1  borrow-out: 1 iff A < B + BIN (unsigned).
- zero  out  1  diff == 0.
- ovf  out  1  signed overflow.

## Operation

- States:
  - IDLE: reset state.
  - RUN: slice count cnt runs 0..N−1.
  - DONE: lasts exactly one cycle.
- Accept: start=1 in IDLE or DONE.
  - Latch a, b, bin into operand registers.
  - Set the borrow register to bin; clear cnt.
  - Go to RUN.
- start while in RUN is ignored; operands and progress are unaffected.
- Each RUN cycle (nibble k = cnt):
  - Compute s = a[k] + ~b[k] + ~borrow as a 5-bit sum.
  - diff nibble k ← s[3:0].
  - borrow ← ~s[4].
  - cnt increments.
- On cnt == N−1, go to DONE. On that edge, bout ← final borrow, zero ← (diff == 0), ovf ← (a_msb ≠ b_msb) & (diff_msb ≠ a_msb).
- DONE:
  - done = 1.
  - Without a start this cycle: go to IDLE. With a start this cycle: accept it (back-to-back).
- diff, bout, zero and ovf hold their last values through IDLE, and through RUN of the next operation until its DONE.
  - Exception: diff nibbles are overwritten progressively during RUN.
  - zero and ovf update only on the final-slice edge.
- Arithmetic is modulo 2^WIDTH. bin=1 with a == b gives diff all-ones and bout=1.

## Timing

- Reset (reset_n=0 at an edge):
  - State → IDLE; cnt=0.
  - busy=0, done=0.
  - diff=0, bout=0, zero=0, ovf=0.
  - Operand registers clear.
  - This applies in any state. A reset mid-RUN abandons the operation with no done pulse.
  - Reset takes priority over start on the same edge.
- Latency: start accepted at edge E0.
  - busy is high from after E0 through edge EN (N cycles).
  - done is high from EN to EN+1.
  - Results are valid from EN.
  - For WIDTH=32: 8 busy cycles, result at E8.
- Throughput: one operation per N+1 cycles. With back-to-back starts, busy drops to 0 only for the DONE cycle.
- busy and done are registered outputs; there are no combinational paths from inputs to outputs.

## Configuration

- NIBSUB_CMP_EN defined:
  - Adds outputs lt_u (1 bit) = bout and lt_s (1 bit) = diff_msb XOR ovf.
  - Both are registered on the final-slice edge, reset to 0, and held like the other results.
  - They are meaningful as compare results when bin=0.
- Undefined: the lt_u and lt_s ports and their registers are absent; all other behaviour is identical.

## Test plan

- WIDTH=32, a=0x00000005, b=0x00000003, bin=0 → done 8 cycles after accept; diff=0x00000002, bout=0, zero=0, ovf=0.
- a=0x00000000, b=0x00000001, bin=0 → diff=0xFFFFFFFF, bout=1, ovf=0. With NIBSUB_CMP_EN: lt_u=1, lt_s=1.
- a=0x80000000, b=0x00000001, bin=0 → diff=0x7FFFFFFF, bout=0, ovf=1. Then a=b=0x12345678: with bin=0 → zero=1, bout=0; with bin=1 → diff=0xFFFFFFFF, bout=1, zero=0.
- Borrow ripple across all nibbles: a=0x10000000, b=0x00000001 → diff=0x0FFFFFFF, bout=0.
- Ignored start: start pulsed at cnt=3 with different operands → result matches the first operands, with done at E8. Back-to-back start in the DONE cycle → second done exactly 9 cycles after the first.
- reset_n low for one edge at cnt=4 → next cycle busy=0, done=0, diff=0, state IDLE. No done pulse follows; a new start completes normally.
